// File: rtl/mux_pkg.sv
// Shared types and limits for the registered N:1 multiplexer family.
package mux_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } mux_state_e;

    localparam int MUX_MAX_N = 64;

endpackage

// File: rtl/mux_nx1_comb.sv
// Purely combinational N*W -> W selector, AND-OR structure generalised from the 8:1 gate-level mux.
module mux_nx1_comb #(
    parameter int N  = 8,
    parameter int W  = 1,
    parameter int SW = $clog2(N)
) (
    input  logic [N*W-1:0] i,
    input  logic [SW-1:0]  sel,
    output logic [W-1:0]   y
);

    logic [W-1:0] term [N];

    // Each channel is gated by its one-hot select term; at most one term is non-zero.
    for (genvar k = 0; k < N; k++) begin : g_term
        assign term[k] = i[k*W +: W] & {W{sel == SW'(k)}};
    end

    always_comb begin
        y = '0;
        for (int k = 0; k < N; k++) begin
            y = y | term[k];
        end
    end

endmodule

// File: rtl/mux_nx1_sync.sv
// Registered N:1 mux with valid/ready output, sticky select error and round-robin scan mode.
// Optional y_par (even parity of y) is built when MUX_NX1_PARITY_EN is defined.
module mux_nx1_sync
    import mux_pkg::*;
#(
    parameter int N  = 8,
    parameter int W  = 1,
    parameter int SW = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N*W-1:0] i,
    input  logic [SW-1:0]  s,
    input  logic           s_load,
    input  logic           scan,
    input  logic           y_ready,
    output logic [W-1:0]   y,
    output logic           y_valid,
    output logic [SW-1:0]  y_ch,
    output logic           err
`ifdef MUX_NX1_PARITY_EN
    ,
    output logic           y_par
`endif
);

    localparam logic [SW-1:0] LAST_CH = SW'(N - 1);
    localparam logic [SW:0]   N_EXT   = (SW + 1)'(N);

    mux_state_e    state_q, state_d;
    logic          scan_active;
    logic          capture;
    logic          s_bad;
    logic          err_set;
    logic [SW-1:0] sel_q, sel_d;
    logic [W-1:0]  mux_out;

    // Wrap against N-1 so non-power-of-2 N never reaches an unused code.
    function automatic logic [SW-1:0] next_sel(input logic [SW-1:0] cur);
        return (cur == LAST_CH) ? '0 : cur + 1'b1;
    endfunction

`ifdef MUX_NX1_PARITY_EN
    function automatic logic calc_par(input logic [W-1:0] d);
        return ^d;
    endfunction
`endif

    mux_nx1_comb #(
        .N  (N),
        .W  (W),
        .SW (SW)
    ) u_comb (
        .i   (i),
        .sel (sel_q),
        .y   (mux_out)
    );

    assign capture = ~y_valid | y_ready;
    assign s_bad   = {1'b0, s} >= N_EXT;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (scan)  state_d = SCAN;
            SCAN:    if (!scan) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Scan is honoured on the entry cycle and on the falling cycle, so every capture made
    // while the mode is asserted or still registered advances the pointer.
    always_comb begin
        scan_active = (state_q == SCAN) | scan;
    end

    always_comb begin
        sel_d   = sel_q;
        err_set = 1'b0;
        if (scan_active) begin
            if (capture) sel_d = next_sel(sel_q);
        end else if (s_load) begin
            if (s_bad) err_set = 1'b1;
            else       sel_d   = s;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_q <= '0;
            err   <= 1'b0;
        end else begin
            sel_q <= sel_d;
            if (err_set) err <= 1'b1;
        end
    end

    // Output slot: capture uses the select in effect before any load this cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y       <= '0;
            y_ch    <= '0;
            y_valid <= 1'b0;
        end else if (capture) begin
            y       <= mux_out;
            y_ch    <= sel_q;
            y_valid <= 1'b1;
        end
    end

`ifdef MUX_NX1_PARITY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_par <= 1'b0;
        end else if (capture) begin
            y_par <= calc_par(mux_out);
        end
    end
`endif

endmodule

// File: tb/tb_mux_nx1_sync.sv
// Directed bench for mux_nx1_sync: an N=8 and an N=6 instance, both W=4.
module tb_mux_nx1_sync;

    logic clk = 1'b0;
    logic rst;

    logic [31:0] i8;
    logic [2:0]  s8;
    logic        sl8, sc8, rdy8;
    logic [3:0]  y8;
    logic        v8, e8;
    logic [2:0]  ch8;

    logic [23:0] i6;
    logic [2:0]  s6;
    logic        sl6, sc6, rdy6;
    logic [3:0]  y6;
    logic        v6, e6;
    logic [2:0]  ch6;

`ifdef MUX_NX1_PARITY_EN
    logic par8, par6;
`endif

    int total  = 0;
    int passed = 0;
    int xfer8  = 0;
    int x0;

    always #5 clk = ~clk;

    mux_nx1_sync #(.N(8), .W(4)) dut8 (
        .clk(clk), .rst(rst), .i(i8), .s(s8), .s_load(sl8), .scan(sc8),
        .y_ready(rdy8), .y(y8), .y_valid(v8), .y_ch(ch8), .err(e8)
`ifdef MUX_NX1_PARITY_EN
        , .y_par(par8)
`endif
    );

    mux_nx1_sync #(.N(6), .W(4)) dut6 (
        .clk(clk), .rst(rst), .i(i6), .s(s6), .s_load(sl6), .scan(sc6),
        .y_ready(rdy6), .y(y6), .y_valid(v6), .y_ch(ch6), .err(e6)
`ifdef MUX_NX1_PARITY_EN
        , .y_par(par6)
`endif
    );

    always @(posedge clk) if (v8 && rdy8) xfer8++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int exp_scan [5] = '{4, 5, 0, 1, 2};

    initial begin
        rst = 1'b1;
        i8 = 32'h76543210; s8 = '0; sl8 = 0; sc8 = 0; rdy8 = 1;
        i6 = 24'h543210;   s6 = '0; sl6 = 0; sc6 = 0; rdy6 = 1;
        #1;
        check("rst_y8", 32'(y8), 0);
        check("rst_v8", 32'(v8), 0);
        check("rst_e6", 32'(e6), 0);
        tick(); tick();
        rst = 1'b0;
        tick();
        check("first_v8", 32'(v8), 1);
        check("first_ch8", 32'(ch8), 0);

        // Manual select: load applies from the following capture
        s8 = 3'd5; sl8 = 1;
        tick();
        sl8 = 0;
        check("load_old_ch8", 32'(ch8), 0);
        tick();
        check("man_y8", 32'(y8), 5);
        check("man_ch8", 32'(ch8), 5);
        tick();
        check("man_y8_b", 32'(y8), 5);

        // Backpressure: output frozen while i changes
        rdy8 = 0;
        for (int k = 0; k < 3; k++) begin
            i8 = i8 + 32'h11111111;
            tick();
            check("stall_y8", 32'(y8), 5);
            check("stall_ch8", 32'(ch8), 5);
            check("stall_v8", 32'(v8), 1);
        end
        x0 = xfer8;
        rdy8 = 1;
        tick();
        rdy8 = 0;
        tick();
        check("one_xfer", 32'(xfer8 - x0), 1);
        check("post_stall_y8", 32'(y8), 8);
        check("post_stall_ch8", 32'(ch8), 5);

`ifdef MUX_NX1_PARITY_EN
        rdy8 = 1;
        i8 = 32'h76B43210;
        tick();
        check("par_y8_b", 32'(y8), 32'hB);
        check("par_b", 32'(par8), 1);
        i8 = 32'h76343210;
        tick();
        check("par_y8_3", 32'(y8), 3);
        check("par_3", 32'(par8), 0);
`endif

        // Out-of-range select on N=6
        s6 = 3'd7; sl6 = 1;
        tick();
        sl6 = 0;
        check("err_set", 32'(e6), 1);
        tick();
        check("err_sel_kept", 32'(ch6), 0);
        s6 = 3'd2; sl6 = 1;
        tick();
        sl6 = 0;
        tick();
        check("err_sticky", 32'(e6), 1);
        check("err_ch6", 32'(ch6), 2);
        check("err_y6", 32'(y6), 2);

        // Scan wrap on N=6 starting at channel 4
        s6 = 3'd4; sl6 = 1;
        tick();
        sl6 = 0;
        tick();
        check("pre_scan_ch6", 32'(ch6), 4);
        sc6 = 1;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("scan_ch6", 32'(ch6), 32'(exp_scan[k]));
            check("scan_y6", 32'(y6), 32'(exp_scan[k]));
        end
        sc6 = 0;
        tick();
        check("scan_fall_ch6", 32'(ch6), 3);
        tick();
        check("idle_ch6_a", 32'(ch6), 4);
        tick();
        check("idle_ch6_b", 32'(ch6), 4);

        // Async reset mid-cycle, no clock edge in between
        #2;
        rst = 1'b1;
        #1;
        check("arst_y6", 32'(y6), 0);
        check("arst_v6", 32'(v6), 0);
        check("arst_ch6", 32'(ch6), 0);
        check("arst_e6", 32'(e6), 0);
        check("arst_v8", 32'(v8), 0);
        check("arst_ch8", 32'(ch8), 0);
        tick();
        rst = 1'b0;
        tick();
        check("rerun_v6", 32'(v6), 1);
        check("rerun_ch6", 32'(ch6), 0);
        check("rerun_e6", 32'(e6), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
